// File: rtl/spi_slave_responder_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// spi_slave_responder_if : SPI pins plus tx/rx word handshake of the responder
// Rev 1.0
// ----------------------------------------------------------------------------
interface spi_slave_responder_if #(
  parameter int N_CHANNELS = 3,
  parameter int DATA_WIDTH = 32
);
  logic                                  SCLK;
  logic                                  SS;
  logic [N_CHANNELS-1:0]                 MOSI;
  logic [N_CHANNELS-1:0]                 MISO;
  logic [N_CHANNELS-1:0][DATA_WIDTH-1:0] tx_data;
  logic                                  tx_valid;
  logic                                  tx_ready;
  logic [N_CHANNELS-1:0][DATA_WIDTH-1:0] rx_data;
  logic                                  rx_valid;
  logic                                  tx_underrun;
  logic                                  aborted;

  modport slave (
    input  SCLK, SS, MOSI, tx_data, tx_valid,
    output MISO, tx_ready, rx_data, rx_valid, tx_underrun, aborted
  );

  modport master (
    output SCLK, SS, MOSI, tx_data, tx_valid,
    input  MISO, tx_ready, rx_data, rx_valid, tx_underrun, aborted
  );
endinterface
`default_nettype wire

// File: rtl/spi_slave_responder.sv
`default_nettype none
// ----------------------------------------------------------------------------
// spi_slave_responder : oversampled multi-lane SPI slave with tx shadow register
// Rev 1.0
// ----------------------------------------------------------------------------
module spi_slave_responder #(
  parameter int N_CHANNELS = 3,
  parameter int DATA_WIDTH = 32
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [4:0] transfer_length,
  input  logic       msb_first,
  input  logic       clock_polarity,
  input  logic       latching_edge,
  input  logic       ss_polarity,
  spi_slave_responder_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  // [0]/[1] synchroniser stages, [2] history for edge detection
  logic [2:0]            sclk_sync;
  logic [2:0]            ss_sync;
  logic [N_CHANNELS-1:0] mosi_s1;
  logic [N_CHANNELS-1:0] mosi_s2;

  logic [5:0] len_cfg;
  logic       msb_cfg;
  logic       edge_cfg;
  logic       cpol_cfg;
  logic       sspol_cfg;

  logic [5:0] bit_count;
  logic [4:0] tx_idx;
  logic       shadow_full;

  logic [N_CHANNELS-1:0][DATA_WIDTH-1:0] shadow_data;
  logic [N_CHANNELS-1:0][DATA_WIDTH-1:0] tx_word;
  logic [N_CHANNELS-1:0][DATA_WIDTH-1:0] rx_shift;
  logic [N_CHANNELS-1:0][DATA_WIDTH-1:0] rx_next;
  logic [N_CHANNELS-1:0][DATA_WIDTH-1:0] rx_word;
  logic [N_CHANNELS-1:0]                 miso;

  logic rx_valid_r;
  logic tx_underrun_r;
  logic aborted_r;

  logic sclk_now;
  logic sclk_prev;
  logic capture_edge;
  logic shift_edge;
  logic ss_start;
  logic ss_active;

  logic start;
  logic capture;
  logic shift;
  logic finish;
  logic abort;

  // Synchronisers are left out of reset so a held SS does not look like a fresh assertion afterwards
  always_ff @(posedge clock) begin
    sclk_sync <= {sclk_sync[1:0], bus.SCLK};
    ss_sync   <= {ss_sync[1:0], bus.SS};
    mosi_s1   <= bus.MOSI;
    mosi_s2   <= mosi_s1;
  end

  assign sclk_now     = sclk_sync[1] ^ cpol_cfg;
  assign sclk_prev    = sclk_sync[2] ^ cpol_cfg;
  assign capture_edge = edge_cfg ? (~sclk_now & sclk_prev) : (sclk_now & ~sclk_prev);
  assign shift_edge   = edge_cfg ? (sclk_now & ~sclk_prev) : (~sclk_now & sclk_prev);
  assign ss_start     = (ss_sync[1] ^ ss_polarity) & ~(ss_sync[2] ^ ss_polarity);
  assign ss_active    = ss_sync[1] ^ sspol_cfg;

  always_ff @(posedge clock) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // A shift edge ahead of the first capture is the leading edge of the first bit, already on MISO
  always_comb begin
    state_next = state;
    start      = 1'b0;
    capture    = 1'b0;
    shift      = 1'b0;
    finish     = 1'b0;
    abort      = 1'b0;
    case (state)
      IDLE: begin
        if (ss_start) begin
          start      = 1'b1;
          state_next = ACTIVE;
        end
      end
      ACTIVE: begin
        if (!ss_active) begin
          abort      = 1'b1;
          state_next = IDLE;
        end else if (capture_edge) begin
          capture = 1'b1;
          if (bit_count + 6'd1 == len_cfg) begin
            finish     = 1'b1;
            state_next = DONE;
          end
        end else if (shift_edge && (bit_count != 6'd0) && (bit_count < len_cfg)) begin
          shift = 1'b1;
        end
      end
      DONE: begin
        if (!ss_active) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    for (int ch = 0; ch < N_CHANNELS; ch++) begin
      rx_next[ch] = rx_shift[ch];
      if (msb_cfg) begin
        rx_next[ch] = {rx_shift[ch][DATA_WIDTH-2:0], mosi_s2[ch]};
      end else begin
        rx_next[ch][bit_count[4:0]] = mosi_s2[ch];
      end
      miso[ch] = (state != IDLE) && tx_word[ch][tx_idx];
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      len_cfg       <= 6'd0;
      msb_cfg       <= 1'b0;
      edge_cfg      <= 1'b0;
      cpol_cfg      <= 1'b0;
      sspol_cfg     <= 1'b0;
      bit_count     <= 6'd0;
      tx_idx        <= 5'd0;
      shadow_full   <= 1'b0;
      shadow_data   <= '0;
      tx_word       <= '0;
      rx_shift      <= '0;
      rx_word       <= '0;
      rx_valid_r    <= 1'b0;
      tx_underrun_r <= 1'b0;
      aborted_r     <= 1'b0;
    end else begin
      rx_valid_r    <= finish;
      tx_underrun_r <= start & ~shadow_full;
      aborted_r     <= abort;

      // Handshake and hand-off are exclusive: a word is only accepted while the shadow is empty
      if (bus.tx_valid && !shadow_full) begin
        shadow_full <= 1'b1;
        shadow_data <= bus.tx_data;
      end else if (start && shadow_full) begin
        shadow_full <= 1'b0;
      end

      if (start) begin
        len_cfg   <= {1'b0, transfer_length} + 6'd1;
        msb_cfg   <= msb_first;
        edge_cfg  <= latching_edge;
        cpol_cfg  <= clock_polarity;
        sspol_cfg <= ss_polarity;
        bit_count <= 6'd0;
        tx_idx    <= msb_first ? transfer_length : 5'd0;
        tx_word   <= shadow_full ? shadow_data : '0;
        rx_shift  <= '0;
      end

      if (capture) begin
        bit_count <= bit_count + 6'd1;
        rx_shift  <= rx_next;
      end

      if (shift) begin
        tx_idx <= msb_cfg ? tx_idx - 5'd1 : tx_idx + 5'd1;
      end

      if (finish) begin
        rx_word <= rx_next;
      end
    end
  end

  assign bus.MISO        = miso;
  assign bus.tx_ready    = ~shadow_full;
  assign bus.rx_data     = rx_word;
  assign bus.rx_valid    = rx_valid_r;
  assign bus.tx_underrun = tx_underrun_r;
  assign bus.aborted     = aborted_r;

endmodule
`default_nettype wire

// File: doc/spi_slave_responder.md
Name: spi_slave_responder

Overview:
- SPI responder (slave end) for the multi-lane SPI master: shared SCLK/SS, N_CHANNELS parallel MOSI/MISO lanes.
- Used for FPGA-to-FPGA links and loopback verification of the master.
- Oversamples asynchronous SPI pins on the system clock.
- Captures incoming words on MOSI; shifts out words supplied via a valid/ready handshake on MISO.

Parameters:
N_CHANNELS, 3, number of parallel MOSI/MISO lanes
DATA_WIDTH, 32, width of parallel tx/rx words (max transfer length)

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-low reset
transfer_length  in  5  bits per transfer = transfer_length+1 (1..32)
msb_first  in  1  1: MSB first, 0: LSB first
clock_polarity  in  1  1: SCLK idles high (inverted before edge detection)
latching_edge  in  1  0: capture on normalised rising edge / shift on falling; 1: opposite
ss_polarity  in  1  0: SS active-high, 1: SS active-low
SCLK  in  1  asynchronous serial clock
SS  in  1  asynchronous chip select
MOSI  in  N_CHANNELS  serial data from master
MISO  out  N_CHANNELS  serial data to master
tx_data  in  N_CHANNELS x DATA_WIDTH  words to transmit
tx_valid  in  1  tx_data valid
tx_ready  out  1  tx shadow register empty
rx_data  out  N_CHANNELS x DATA_WIDTH  received words, right-justified, upper bits 0
rx_valid  out  1  one-cycle pulse, rx_data updated
tx_underrun  out  1  one-cycle pulse: transfer started with empty shadow
aborted  out  1  one-cycle pulse: SS deasserted before last bit

Behaviour:
- Input sync:
  - SCLK, SS, MOSI pass through 2-FF synchronisers plus one history FF for edge detection.
  - SCLK frequency must be ≤ clock/8.
  - Pin-to-detected-edge latency: 3 cycles.
- Reset values:
  - MISO = 0, tx_ready = 1, rx_data = 0.
  - rx_valid, tx_underrun, aborted = 0.
  - State IDLE, bit counter 0, shadow empty.
- TX handshake:
  - Shadow loads when tx_valid & tx_ready; tx_ready drops the next cycle.
  - tx_ready returns high the cycle after the shadow is moved to the shift register.
  - tx_valid while tx_ready=0 is ignored; the word is not consumed.
- FSM:
  - IDLE: MISO = 0. On detected SS assertion:
    - Latch config: length, msb_first, edge, polarities.
    - Move shadow to the shift register, or load zeros and pulse tx_underrun if the shadow is empty.
    - Present first bit on MISO in the same cycle → ACTIVE.
  - ACTIVE:
    - Capture edge: sample MOSI into the rx shift register; bit_count += 1.
    - Shift edge: advance MISO to the next bit, but only if bit_count < length.
    - Transition: bit_count == length → DONE; SS deassert with bit_count < length → pulse aborted → IDLE, rx_data unchanged, no rx_valid.
  - DONE:
    - rx_data <= received word (bit order per msb_first), rx_valid pulses once on DONE entry.
    - Further SCLK edges are ignored; MISO holds the last bit.
    - SS deassert → IDLE.
- Simultaneous events:
  - Capture edge coincident with SS deassert: SS deassert wins; the edge is discarded.
  - tx_valid handshake coincident with SS assertion: the word goes to the shadow for the next transfer; the current transfer uses the prior shadow content or underruns.
  - SS re-asserted in the same cycle DONE→IDLE completes: handled as a new transfer on the next cycle.
- Config changes mid-transfer have no effect until the next SS assertion.
- Reset mid-transfer: immediate return to reset values; any partial word is discarded.
- Bit counter is 6 bits wide; length 32 must not wrap.

Test Plan:
- Single transfer: length=15 (16 bits), msb_first=1, SS active-high, SCLK = clock/8, master sends 0xA5C3 on lane 0; tx_data[0]=0x1234 → rx_data[0]=0x0000A5C3 with one rx_valid pulse; MISO lane 0 carries 0x1234 MSB first; tx_ready=1 after the transfer.
- All lanes, 32 bits, LSB first, clock_polarity=1, latching_edge=1: lanes send 0xDEADBEEF / 0x00000001 / 0x80000000 → rx_data matches exactly on all lanes; MISO returns the preloaded words bit-exact.
- Underrun: no tx_valid before SS assertion → tx_underrun pulses 1 cycle after SS detection; MISO stays 0 for the whole transfer; rx still captured.
- Abort: length=7, SS deasserted after 4 capture edges → aborted pulses; rx_valid stays 0; rx_data holds its previous value; next full transfer succeeds.
- Back-to-back: two 8-bit transfers with a 2-SCLK-period SS gap, second tx word handshaken during the first transfer → both rx_valid pulses; second MISO word correct; no underrun.
- Reset mid-transfer after 3 bits → MISO=0, tx_ready=1, no rx_valid; a subsequent transfer is correct.
